flood_game_ctrl: RTL and testbench

- Top-level sequencer for one Flood-It game.
- Latches and clamps the player's size, colour-count and seed selection, then runs the board-generator handshake (INITIALIZE_BOARD / BOARD_READY).
- Accepts colour moves, dispatches each to the flood-fill engine, counts moves and declares win or loss against a computed move limit.

---
 rtl/flood_game_ctrl_if.sv | 38 +++
 rtl/flood_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_flood_game_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/flood_game_ctrl_if.sv
// rtl/flood_game_ctrl_if.sv - player, generator and flood-engine signals of one Flood-It game
interface flood_game_ctrl_if;
    logic        start_req;
    logic [4:0]  size_sel;
    logic [3:0]  color_sel;
    logic [15:0] seed_in;
    logic        INITIALIZE_BOARD;
    logic [4:0]  final_SIZE;
    logic [3:0]  final_COLOR_NUM;
    logic [15:0] seed;
    logic        BOARD_READY;
    logic [2:0]  corner_color;
    logic        move_valid;
    logic [2:0]  move_color;
    logic        flood_start;
    logic [2:0]  flood_color;
    logic        flood_done;
    logic        flood_won;
    logic [7:0]  move_count;
    logic [7:0]  move_limit;
    logic [2:0]  state_out;
    logic        game_won;
    logic        game_lost;

    modport master (
        output start_req, size_sel, color_sel, seed_in, BOARD_READY, corner_color,
               move_valid, move_color, flood_done, flood_won,
        input  INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM, seed, flood_start,
               flood_color, move_count, move_limit, state_out, game_won, game_lost
    );

    modport slave (
        input  start_req, size_sel, color_sel, seed_in, BOARD_READY, corner_color,
               move_valid, move_color, flood_done, flood_won,
        output INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM, seed, flood_start,
               flood_color, move_count, move_limit, state_out, game_won, game_lost
    );
endinterface

// File: rtl/flood_game_ctrl.sv
// rtl/flood_game_ctrl.sv - Flood-It game sequencer: setup latch, generator handshake, move dispatch, win/loss
module flood_game_ctrl #(
    parameter int MIN_SIZE   = 2,
    parameter int MAX_SIZE   = 26,
    parameter int MIN_COLORS = 3,
    parameter int MAX_COLORS = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    flood_game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GEN_REQ = 3'd1,
        S_GEN_REL = 3'd2,
        S_PLAY    = 3'd3,
        S_FLOOD   = 3'd4,
        S_WON     = 3'd5,
        S_LOST    = 3'd6
    } state_t;

    state_t      state_q;
    logic [4:0]  final_size_q;
    logic [3:0]  final_color_q;
    logic [15:0] seed_q;
    logic [7:0]  move_limit_q;
    logic [7:0]  move_count_q;
    logic        init_q;
    logic        flood_start_q;
    logic [2:0]  flood_color_q;
    logic        won_q;
    logic        lost_q;

    logic [4:0]  size_clamp_d;
    logic [3:0]  color_clamp_d;
    logic [8:0]  area_d;
    logic [7:0]  limit_d;
    logic        start_ok_d;
    logic        move_legal_d;

    always_comb begin
        size_clamp_d = bus.size_sel;
        if (bus.size_sel < 5'(MIN_SIZE))
            size_clamp_d = 5'(MIN_SIZE);
        else if (bus.size_sel > 5'(MAX_SIZE))
            size_clamp_d = 5'(MAX_SIZE);

        color_clamp_d = bus.color_sel;
        if (bus.color_sel < 4'(MIN_COLORS))
            color_clamp_d = 4'(MIN_COLORS);
        else if (bus.color_sel > 4'(MAX_COLORS))
            color_clamp_d = 4'(MAX_COLORS);

        area_d  = 9'(size_clamp_d) * 9'(color_clamp_d);
        limit_d = 8'((area_d >> 2) + 9'd1);

        start_ok_d = bus.start_req &&
                     (state_q == S_IDLE || state_q == S_PLAY ||
                      state_q == S_WON  || state_q == S_LOST);

        move_legal_d = bus.move_valid &&
                       ({1'b0, bus.move_color} < final_color_q) &&
                       (bus.move_color != bus.corner_color);
    end

    // Start takes priority over every per-state action, so a coincident move is dropped.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            final_size_q  <= 5'(MIN_SIZE);
            final_color_q <= 4'(MIN_COLORS);
            seed_q        <= '0;
            move_limit_q  <= '0;
            move_count_q  <= '0;
            init_q        <= 1'b0;
            flood_start_q <= 1'b0;
            flood_color_q <= '0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            flood_start_q <= 1'b0;
            if (start_ok_d) begin
                final_size_q  <= size_clamp_d;
                final_color_q <= color_clamp_d;
                seed_q        <= bus.seed_in;
                move_limit_q  <= limit_d;
                move_count_q  <= '0;
                won_q         <= 1'b0;
                lost_q        <= 1'b0;
                init_q        <= 1'b1;
                state_q       <= S_GEN_REQ;
            end else begin
                case (state_q)
                    S_GEN_REQ: begin
                        if (bus.BOARD_READY) begin
                            init_q  <= 1'b0;
                            state_q <= S_GEN_REL;
                        end
                    end
                    S_GEN_REL: begin
                        if (!bus.BOARD_READY)
                            state_q <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (move_legal_d) begin
                            flood_start_q <= 1'b1;
                            flood_color_q <= bus.move_color;
                            if (move_count_q != 8'hFF)
                                move_count_q <= move_count_q + 8'd1;
                            state_q <= S_FLOOD;
                        end
                    end
                    S_FLOOD: begin
                        if (bus.flood_done) begin
                            if (bus.flood_won) begin
                                won_q   <= 1'b1;
                                state_q <= S_WON;
                            end else if (move_count_q == move_limit_q) begin
                                lost_q  <= 1'b1;
                                state_q <= S_LOST;
                            end else begin
                                state_q <= S_PLAY;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.INITIALIZE_BOARD = init_q;
    assign bus.final_SIZE       = final_size_q;
    assign bus.final_COLOR_NUM  = final_color_q;
    assign bus.seed             = seed_q;
    assign bus.flood_start      = flood_start_q;
    assign bus.flood_color      = flood_color_q;
    assign bus.move_count       = move_count_q;
    assign bus.move_limit       = move_limit_q;
    assign bus.state_out        = state_q;
    assign bus.game_won         = won_q;
    assign bus.game_lost        = lost_q;
endmodule

// File: tb/tb_flood_game_ctrl.sv
// tb/tb_flood_game_ctrl.sv - scoreboard bench for flood_game_ctrl
module tb_flood_game_ctrl;
    logic clk;
    logic rst;
    flood_game_ctrl_if bus ();

    flood_game_ctrl dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  size;
        logic [3:0]  col;
        logic [15:0] seed;
        logic [7:0]  lim;
    } start_exp_t;

    typedef struct {
        logic [2:0] col;
        logic [7:0] cnt;
    } move_exp_t;

    start_exp_t start_q[$];
    move_exp_t  move_q[$];
    int n_checks = 0;
    int n_errors = 0;
    logic init_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (bus.INITIALIZE_BOARD && !init_prev) begin
            if (start_q.size() == 0) begin
                chk("init_unexpected", 32'd1, 32'd0);
            end else begin
                start_exp_t e;
                e = start_q.pop_front();
                chk("final_size", bus.final_SIZE, e.size);
                chk("final_color", bus.final_COLOR_NUM, e.col);
                chk("seed", bus.seed, e.seed);
                chk("move_limit", bus.move_limit, e.lim);
                chk("start_count", bus.move_count, 0);
                chk("start_flags", {bus.game_won, bus.game_lost}, 0);
                chk("start_state", bus.state_out, 1);
            end
        end
        init_prev = bus.INITIALIZE_BOARD;
        if (bus.flood_start) begin
            if (move_q.size() == 0) begin
                chk("flood_unexpected", 32'd1, 32'd0);
            end else begin
                move_exp_t m;
                m = move_q.pop_front();
                chk("flood_color", bus.flood_color, m.col);
                chk("flood_count", bus.move_count, m.cnt);
                chk("flood_state", bus.state_out, 4);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [4:0] s, input logic [3:0] c, input logic [15:0] sd,
                            input logic [4:0] es, input logic [3:0] ec, input logic [7:0] el);
        start_exp_t e;
        e.size = es; e.col = ec; e.seed = sd; e.lim = el;
        start_q.push_back(e);
        bus.start_req = 1'b1; bus.size_sel = s; bus.color_sel = c; bus.seed_in = sd;
        tick();
        bus.start_req = 1'b0;
    endtask

    task automatic gen_board();
        bus.BOARD_READY = 1'b1;
        tick();
        bus.BOARD_READY = 1'b0;
        tick();
        chk("gen_play", bus.state_out, 3);
    endtask

    task automatic move(input logic [2:0] c, input logic legal, input logic [7:0] cnt);
        move_exp_t m;
        if (legal) begin
            m.col = c; m.cnt = cnt;
            move_q.push_back(m);
        end
        bus.move_valid = 1'b1; bus.move_color = c;
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic done(input logic w);
        bus.flood_done = 1'b1; bus.flood_won = w;
        tick();
        bus.flood_done = 1'b0; bus.flood_won = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start_req = 0; bus.size_sel = 0; bus.color_sel = 0; bus.seed_in = 0;
        bus.BOARD_READY = 0; bus.corner_color = 0; bus.move_valid = 0; bus.move_color = 0;
        bus.flood_done = 0; bus.flood_won = 0;
        tick(); tick();
        chk("rst_state", bus.state_out, 0);
        chk("rst_size", bus.final_SIZE, 2);
        chk("rst_color", bus.final_COLOR_NUM, 3);
        chk("rst_outs", {bus.INITIALIZE_BOARD, bus.flood_start, bus.seed, bus.move_count, bus.move_limit}, 0);
        rst = 1'b0;
        tick();

        do_start(5'd14, 4'd6, 16'hBEEF, 5'd14, 4'd6, 8'd22);
        chk("init_high", bus.INITIALIZE_BOARD, 1);
        bus.start_req = 1'b1; bus.size_sel = 5'd5; bus.color_sel = 4'd4;
        tick();
        bus.start_req = 1'b0;
        chk("genreq_start_ignored", {bus.final_SIZE, bus.final_COLOR_NUM}, {5'd14, 4'd6});
        for (int i = 0; i < 38; i++) begin
            chk("genreq_hold", {bus.state_out, bus.INITIALIZE_BOARD}, {3'd1, 1'b1});
            tick();
        end
        bus.BOARD_READY = 1'b1;
        tick();
        chk("genrel_init", bus.INITIALIZE_BOARD, 0);
        chk("genrel_state", bus.state_out, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("genrel_hold", bus.state_out, 2);
        end
        bus.BOARD_READY = 1'b0;
        tick();
        chk("play_state", bus.state_out, 3);

        do_start(5'd30, 4'd2, 16'h0000, 5'd26, 4'd3, 8'd20);
        gen_board();
        do_start(5'd0, 4'd15, 16'h1234, 5'd2, 4'd8, 8'd5);
        gen_board();

        do_start(5'd4, 4'd4, 16'hA5A5, 5'd4, 4'd4, 8'd5);
        gen_board();
        bus.corner_color = 3'd2;
        move(3'd2, 1'b0, 0);
        chk("drop_corner", {bus.state_out, bus.move_count}, {3'd3, 8'd0});
        move(3'd5, 1'b0, 0);
        chk("drop_range", {bus.state_out, bus.move_count}, {3'd3, 8'd0});
        move(3'd4, 1'b0, 0);
        chk("drop_edge", {bus.state_out, bus.move_count}, {3'd3, 8'd0});
        move(3'd1, 1'b1, 8'd1);
        move(3'd3, 1'b0, 0);
        chk("flood_ignore_move", {bus.state_out, bus.move_count, bus.flood_color}, {3'd4, 8'd1, 3'd1});
        done(1'b0);
        chk("back_to_play", bus.state_out, 3);
        for (int i = 2; i <= 5; i++) begin
            move((i % 2 == 0) ? 3'd3 : 3'd1, 1'b1, 8'(i));
            done(i == 5);
        end
        chk("won_state", {bus.state_out, bus.game_won, bus.game_lost}, {3'd5, 1'b1, 1'b0});
        move(3'd1, 1'b0, 0);
        done(1'b0);
        chk("won_hold", {bus.state_out, bus.move_count}, {3'd5, 8'd5});

        do_start(5'd4, 4'd4, 16'h0001, 5'd4, 4'd4, 8'd5);
        gen_board();
        bus.corner_color = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            move(3'(1 + (i % 3)), 1'b1, 8'(i));
            done(1'b0);
        end
        chk("lost_state", {bus.state_out, bus.game_won, bus.game_lost}, {3'd6, 1'b0, 1'b1});

        do_start(5'd4, 4'd4, 16'h0002, 5'd4, 4'd4, 8'd5);
        gen_board();
        bus.start_req = 1'b1; bus.move_valid = 1'b1; bus.move_color = 3'd1;
        start_q.push_back('{5'd4, 4'd4, 16'h0002, 8'd5});
        tick();
        bus.start_req = 1'b0; bus.move_valid = 1'b0;
        chk("start_beats_move", {bus.state_out, bus.move_count}, {3'd1, 8'd0});
        gen_board();
        move(3'd1, 1'b1, 8'd1);
        chk("pre_reset_flood", bus.state_out, 4);
        #2 rst = 1'b1;
        #1;
        chk("areset_state", bus.state_out, 0);
        chk("areset_init", bus.INITIALIZE_BOARD, 0);
        chk("areset_outs", {bus.flood_start, bus.flood_color, bus.move_count, bus.move_limit, bus.seed}, 0);
        chk("areset_cfg", {bus.final_SIZE, bus.final_COLOR_NUM, bus.game_won, bus.game_lost}, {5'd2, 4'd3, 2'b00});
        tick();
        rst = 1'b0;
        tick();
        done(1'b1);
        chk("post_reset_done", {bus.state_out, bus.game_won}, {3'd0, 1'b0});
        tick();

        chk("start_q_empty", start_q.size(), 0);
        chk("move_q_empty", move_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
